// File: rtl/trng_uart_drain_ctrl_if.sv
// FIFO read port and UART byte port seen by the drain controller.
interface trng_uart_drain_ctrl_if;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [31:0] fifo_rd_data;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;

  // master: the drain controller; slave: the FIFO/UART side
  modport master (
    input  fifo_empty, fifo_rd_data, tx_busy,
    output fifo_rd_en, tx_data, tx_start
  );
  modport slave (
    output fifo_empty, fifo_rd_data, tx_busy,
    input  fifo_rd_en, tx_data, tx_start
  );
endinterface

// File: rtl/trng_uart_drain_ctrl.sv
// Drains 32-bit random words from the output FIFO and sends each as four UART bytes.
module trng_uart_drain_ctrl #(
  parameter bit          MSB_FIRST = 1'b1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   single_shot,
  input  logic [CNT_W-1:0]       word_limit,
  trng_uart_drain_ctrl_if.master bus,
  output logic                   busy,
  output logic [CNT_W-1:0]       words_sent,
  output logic                   done
);

  localparam int unsigned CMP_W = CNT_W + 1;

  typedef enum logic [2:0] {
    IDLE, SCAN, POP, CAP, SEND, WAIT_ACK, WAIT_FREE
  } state_t;

  typedef enum logic {
    SINGLE, STREAM
  } mode_t;

  state_t           state;
  mode_t            mode;
  logic [CNT_W-1:0] limit_q;
  logic [31:0]      word_q;
  logic [1:0]       byte_idx;

  logic [1:0]       byte_pos_c;
  logic [7:0]       byte_c;
  logic             limit_hit_c;

  // Byte lane for the current index; MSB-first walks lanes 3..0
  always_comb begin
    byte_pos_c = MSB_FIRST ? ~byte_idx : byte_idx;
    byte_c     = 8'h00;
    case (byte_pos_c)
      2'd0:    byte_c = word_q[7:0];
      2'd1:    byte_c = word_q[15:8];
      2'd2:    byte_c = word_q[23:16];
      default: byte_c = word_q[31:24];
    endcase
  end

  // Word about to complete is the last one allowed by a nonzero limit
  always_comb begin
    limit_hit_c = (limit_q != '0) &&
                  (({1'b0, words_sent} + CMP_W'(1)) == {1'b0, limit_q});
  end

  // Sequencer with registered strobes and status
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      mode           <= SINGLE;
      limit_q        <= '0;
      word_q         <= '0;
      byte_idx       <= '0;
      busy           <= 1'b0;
      words_sent     <= '0;
      done           <= 1'b0;
      bus.fifo_rd_en <= 1'b0;
      bus.tx_start   <= 1'b0;
      bus.tx_data    <= '0;
    end else begin
      bus.fifo_rd_en <= 1'b0;
      bus.tx_start   <= 1'b0;
      done           <= 1'b0;
      unique case (state)
        IDLE: begin
          if (single_shot && !bus.fifo_empty) begin
            words_sent     <= '0;
            mode           <= SINGLE;
            busy           <= 1'b1;
            bus.fifo_rd_en <= 1'b1;
            state          <= POP;
          end else if (enable) begin
            words_sent <= '0;
            limit_q    <= word_limit;
            mode       <= STREAM;
            busy       <= 1'b1;
            state      <= SCAN;
          end
        end
        SCAN: begin
          if (!enable) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end else if (!bus.fifo_empty) begin
            bus.fifo_rd_en <= 1'b1;
            state          <= POP;
          end
        end
        POP: begin
          state <= CAP;
        end
        CAP: begin
          word_q   <= bus.fifo_rd_data;
          byte_idx <= '0;
          state    <= SEND;
        end
        SEND: begin
          if (!bus.tx_busy) begin
            bus.tx_data  <= byte_c;
            bus.tx_start <= 1'b1;
            state        <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (bus.tx_busy) begin
            state <= WAIT_FREE;
          end
        end
        WAIT_FREE: begin
          if (!bus.tx_busy) begin
            if (byte_idx != 2'd3) begin
              byte_idx <= byte_idx + 2'd1;
              state    <= SEND;
            end else begin
              if (words_sent != '1) begin
                words_sent <= words_sent + CNT_W'(1);
              end
              if (mode == SINGLE || limit_hit_c || !enable) begin
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= IDLE;
              end else begin
                state <= SCAN;
              end
            end
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trng_uart_drain_ctrl.sv
// Bench: FIFO and UART models around an MSB-first and an LSB-first controller.
module tb_trng_uart_drain_ctrl;

  localparam int unsigned CNT_W    = 16;
  localparam int unsigned UART_CYC = 10;
  localparam int          DEPTH    = 16;
  localparam int          EXP_N    = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             en [2];
  logic             ss [2];
  logic [CNT_W-1:0] word_limit;

  logic             busy0, busy1, done0, done1;
  logic [CNT_W-1:0] ws0, ws1;

  trng_uart_drain_ctrl_if bus0 ();
  trng_uart_drain_ctrl_if bus1 ();

  trng_uart_drain_ctrl #(.MSB_FIRST(1'b1), .CNT_W(CNT_W)) dut_msb (
    .clk(clk), .rst(rst), .enable(en[0]), .single_shot(ss[0]),
    .word_limit(word_limit), .bus(bus0),
    .busy(busy0), .words_sent(ws0), .done(done0)
  );

  trng_uart_drain_ctrl #(.MSB_FIRST(1'b0), .CNT_W(CNT_W)) dut_lsb (
    .clk(clk), .rst(rst), .enable(en[1]), .single_shot(ss[1]),
    .word_limit(word_limit), .bus(bus1),
    .busy(busy1), .words_sent(ws1), .done(done1)
  );

  // Per-lane views of DUT outputs
  logic             rd_en_a [2];
  logic             tx_st_a [2];
  logic [7:0]       tx_d_a  [2];
  logic             busy_a  [2];
  logic             done_a  [2];
  logic [CNT_W-1:0] ws_a    [2];
  assign rd_en_a[0] = bus0.fifo_rd_en;
  assign rd_en_a[1] = bus1.fifo_rd_en;
  assign tx_st_a[0] = bus0.tx_start;
  assign tx_st_a[1] = bus1.tx_start;
  assign tx_d_a[0]  = bus0.tx_data;
  assign tx_d_a[1]  = bus1.tx_data;
  assign busy_a[0]  = busy0;
  assign busy_a[1]  = busy1;
  assign done_a[0]  = done0;
  assign done_a[1]  = done1;
  assign ws_a[0]    = ws0;
  assign ws_a[1]    = ws1;

  // FIFO and UART environment models
  logic [31:0] fmem [2][DEPTH];
  int          ftail [2] = '{0, 0};
  int          fhead [2] = '{0, 0};
  logic [31:0] rdq   [2] = '{32'h0, 32'h0};
  logic        ubusy [2] = '{1'b0, 1'b0};
  int          ucnt  [2] = '{0, 0};

  assign bus0.fifo_empty   = (fhead[0] == ftail[0]);
  assign bus1.fifo_empty   = (fhead[1] == ftail[1]);
  assign bus0.fifo_rd_data = rdq[0];
  assign bus1.fifo_rd_data = rdq[1];
  assign bus0.tx_busy      = ubusy[0];
  assign bus1.tx_busy      = ubusy[1];

  // Pop returns data next cycle; UART busy rises the cycle after tx_start
  always @(posedge clk) begin
    for (int l = 0; l < 2; l++) begin
      if (rd_en_a[l] && fhead[l] != ftail[l]) begin
        rdq[l]   <= fmem[l][fhead[l] % DEPTH];
        fhead[l] <= fhead[l] + 1;
      end
      if (tx_st_a[l]) begin
        ubusy[l] <= 1'b1;
        ucnt[l]  <= UART_CYC - 1;
      end else if (ubusy[l]) begin
        if (ucnt[l] == 0) ubusy[l] <= 1'b0;
        else              ucnt[l]  <= ucnt[l] - 1;
      end
    end
  end

  // Scoreboard state
  int          errors = 0;
  int          checks = 0;
  logic [7:0]  exp_b  [2][EXP_N];
  int          exp_wr [2] = '{0, 0};
  int          exp_rd [2] = '{0, 0};
  int          n_rd   [2] = '{0, 0};
  int          n_tx   [2] = '{0, 0};
  int          n_done [2] = '{0, 0};
  logic [7:0]  log_b  [2][16];
  int          log_n  [2] = '{0, 0};
  logic        track  [2] = '{1'b0, 1'b0};
  logic [7:0]  cur_b  [2] = '{8'h0, 8'h0};
  logic        prev_dn[2] = '{1'b0, 1'b0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int l, input logic [31:0] w);
    fmem[l][ftail[l] % DEPTH] = w;
    ftail[l]++;
  endtask

  task automatic clear_counts();
    for (int l = 0; l < 2; l++) begin
      n_rd[l] = 0; n_tx[l] = 0; n_done[l] = 0; log_n[l] = 0;
    end
  endtask

  // Per-cycle comparison against the byte stream implied by popped words
  task automatic monitor();
    for (int l = 0; l < 2; l++) begin
      if (rd_en_a[l] === 1'b1) begin
        n_rd[l]++;
        chk("rd_en_not_empty", 32'(fhead[l] != ftail[l]), 32'd1);
        if (fhead[l] != ftail[l]) begin
          for (int k = 0; k < 4; k++) begin
            exp_b[l][exp_wr[l] % EXP_N] = (l == 0)
              ? 8'(fmem[l][fhead[l] % DEPTH] >> (8 * (3 - k)))
              : 8'(fmem[l][fhead[l] % DEPTH] >> (8 * k));
            exp_wr[l]++;
          end
        end
      end
      if (tx_st_a[l] === 1'b1) begin
        n_tx[l]++;
        chk("tx_start_uart_idle", 32'(ubusy[l]), 32'd0);
        chk("tx_byte_pending", 32'(exp_wr[l] > exp_rd[l]), 32'd1);
        if (exp_wr[l] > exp_rd[l]) begin
          chk("tx_byte", 32'(tx_d_a[l]), 32'(exp_b[l][exp_rd[l] % EXP_N]));
          exp_rd[l]++;
        end
        if (log_n[l] < 16) log_b[l][log_n[l]] = tx_d_a[l];
        log_n[l]++;
        track[l] = 1'b1;
        cur_b[l] = tx_d_a[l];
      end else if (track[l] && ubusy[l]) begin
        chk("tx_data_stable", 32'(tx_d_a[l]), 32'(cur_b[l]));
      end else if (!ubusy[l]) begin
        track[l] = 1'b0;
      end
      if (done_a[l] === 1'b1) begin
        n_done[l]++;
        chk("done_one_cycle", 32'(prev_dn[l]), 32'd0);
        chk("busy_low_at_done", 32'(busy_a[l]), 32'd0);
        chk("words_at_done", 32'(ws_a[l]), 32'(n_tx[l] / 4));
        chk("whole_words_at_done", 32'(n_tx[l] % 4), 32'd0);
      end
      prev_dn[l] = done_a[l];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    monitor();
  endtask

  task automatic wait_done(input int l, input int max);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max && !seen; i++) begin
      tick();
      if (done_a[l] === 1'b1) begin
        seen  = 1'b1;
        en[l] = 1'b0;
      end
    end
    chk("done_seen", 32'(seen), 32'd1);
  endtask

  task automatic wait_tx(input int l, input int n, input int max);
    for (int i = 0; i < max && n_tx[l] < n; i++) tick();
    chk("tx_count_reached", 32'(n_tx[l] >= n), 32'd1);
  endtask

  task automatic wait_frame_end(input int l);
    for (int i = 0; i < 5 && !ubusy[l]; i++) tick();
    for (int i = 0; i < 2 * UART_CYC && ubusy[l]; i++) tick();
    chk("frame_end", 32'(ubusy[l]), 32'd0);
  endtask

  logic [7:0] ref4 [4];
  bit         all_busy;
  int         k;

  initial begin
    rst = 1'b1; word_limit = '0;
    en[0] = 1'b0; en[1] = 1'b0; ss[0] = 1'b0; ss[1] = 1'b0;
    tick(); tick();
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_words", 32'(ws0), 32'd0);
    chk("rst_done", 32'(done0), 32'd0);
    chk("rst_rd_en", 32'(bus0.fifo_rd_en), 32'd0);
    chk("rst_tx_start", 32'(bus0.tx_start), 32'd0);
    chk("rst_tx_data", 32'(bus0.tx_data), 32'd0);
    chk("rst_busy_lsb", 32'(busy1), 32'd0);
    rst = 1'b0;
    tick();

    // Single word, MSB first, with start latency
    push(0, 32'hA1B2C3D4);
    clear_counts();
    tick();
    ss[0] = 1'b1;
    tick();
    ss[0] = 1'b0;
    chk("pop_after_start", 32'(bus0.fifo_rd_en), 32'd1);
    k = 0;
    while (k < 10 && bus0.tx_start !== 1'b1) begin tick(); k++; end
    chk("first_tx_latency", 32'(k), 32'd3);
    wait_done(0, 200);
    repeat (5) tick();
    ref4 = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    for (int i = 0; i < 4; i++) chk("single_byte", 32'(log_b[0][i]), 32'(ref4[i]));
    chk("single_pops", 32'(n_rd[0]), 32'd1);
    chk("single_dones", 32'(n_done[0]), 32'd1);
    chk("single_words", 32'(ws0), 32'd1);
    chk("single_busy_after", 32'(busy0), 32'd0);

    // Stream with limit 3 out of 5 queued words
    push(0, 32'h01020304); push(0, 32'h05060708); push(0, 32'h090A0B0C);
    push(0, 32'h0D0E0F10); push(0, 32'h11121314);
    clear_counts();
    word_limit = 16'd3;
    en[0] = 1'b1;
    wait_done(0, 400);
    word_limit = 16'd1;
    repeat (5) tick();
    chk("limit_pops", 32'(n_rd[0]), 32'd3);
    chk("limit_tx", 32'(n_tx[0]), 32'd12);
    chk("limit_dones", 32'(n_done[0]), 32'd1);
    chk("limit_words", 32'(ws0), 32'd3);
    chk("limit_left", 32'(ftail[0] - fhead[0]), 32'd2);

    // Unlimited stream starving on the two leftovers, then refilled
    clear_counts();
    word_limit = '0;
    en[0] = 1'b1;
    wait_tx(0, 8, 300);
    wait_frame_end(0);
    all_busy = 1'b1;
    repeat (50) begin tick(); if (busy0 !== 1'b1) all_busy = 1'b0; end
    chk("busy_while_starved", 32'(all_busy), 32'd1);
    chk("no_pop_while_starved", 32'(n_rd[0]), 32'd2);
    push(0, 32'hCAFEF00D);
    wait_tx(0, 12, 300);
    wait_frame_end(0);
    repeat (5) tick();
    chk("busy_in_scan", 32'(busy0), 32'd1);
    en[0] = 1'b0;
    wait_done(0, 20);
    chk("starve_words", 32'(ws0), 32'd3);
    chk("starve_pops", 32'(n_rd[0]), 32'd3);
    chk("starve_dones", 32'(n_done[0]), 32'd1);

    // Enable dropped after the second byte
    push(0, 32'h11223344); push(0, 32'h55667788);
    clear_counts();
    en[0] = 1'b1;
    wait_tx(0, 2, 200);
    en[0] = 1'b0;
    wait_done(0, 200);
    repeat (30) tick();
    ref4 = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) chk("midstop_byte", 32'(log_b[0][i]), 32'(ref4[i]));
    chk("midstop_tx", 32'(n_tx[0]), 32'd4);
    chk("midstop_pops", 32'(n_rd[0]), 32'd1);
    chk("midstop_words", 32'(ws0), 32'd1);
    chk("midstop_left", 32'(ftail[0] - fhead[0]), 32'd1);

    // Reset while waiting for byte 2's frame to finish
    clear_counts();
    en[0] = 1'b1;
    wait_tx(0, 2, 200);
    for (int i = 0; i < 5 && !ubusy[0]; i++) tick();
    tick();
    rst = 1'b1;
    en[0] = 1'b0;
    track[0] = 1'b0;
    tick();
    chk("rst_mid_tx_start", 32'(bus0.tx_start), 32'd0);
    chk("rst_mid_rd_en", 32'(bus0.fifo_rd_en), 32'd0);
    chk("rst_mid_busy", 32'(busy0), 32'd0);
    chk("rst_mid_words", 32'(ws0), 32'd0);
    rst = 1'b0;
    exp_rd[0] = exp_wr[0];
    repeat (40) tick();
    chk("rst_mid_no_more_tx", 32'(n_tx[0]), 32'd2);
    chk("rst_mid_pops", 32'(n_rd[0]), 32'd1);
    chk("rst_mid_dones", 32'(n_done[0]), 32'd0);

    // LSB-first instance
    push(1, 32'hA1B2C3D4);
    clear_counts();
    tick();
    ss[1] = 1'b1;
    tick();
    ss[1] = 1'b0;
    wait_done(1, 200);
    repeat (5) tick();
    ref4 = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
    for (int i = 0; i < 4; i++) chk("lsb_byte", 32'(log_b[1][i]), 32'(ref4[i]));
    chk("lsb_words", 32'(ws1), 32'd1);
    chk("lsb_pops", 32'(n_rd[1]), 32'd1);
    chk("lsb_dones", 32'(n_done[1]), 32'd1);

    // single_shot on an empty FIFO is ignored
    clear_counts();
    ss[0] = 1'b1;
    tick();
    ss[0] = 1'b0;
    repeat (20) tick();
    chk("empty_ss_pops", 32'(n_rd[0]), 32'd0);
    chk("empty_ss_tx", 32'(n_tx[0]), 32'd0);
    chk("empty_ss_dones", 32'(n_done[0]), 32'd0);
    chk("empty_ss_busy", 32'(busy0), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/trng_uart_drain_ctrl.md
Name: trng_uart_drain_ctrl

Overview:
- Sequencer that drains 32-bit random words from the output FIFO (fifo32 instance fed by the PicoRV32 MMIO path) and serialises each word into four bytes toward a byte-wide UART transmitter.
- Replaces the push-button pop on the output FIFO for the UART build.
- Supports single-word requests and continuous streaming with an optional word limit.
- Sits between the output fifo32 read port and the uart_tx byte interface.

Parameters:
- MSB_FIRST, 1, 1: send word[31:24] first; 0: send word[7:0] first.
- CNT_W, 16, width of word_limit and words_sent.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- enable  in  1  level; while high, stream words continuously.
- single_shot  in  1  one-cycle pulse; send exactly one word.
- word_limit  in  CNT_W  words per streaming run; 0 = unlimited; sampled at run start.
- fifo_empty  in  1  output FIFO empty flag.
- fifo_rd_en  out  1  one-cycle pop strobe to output FIFO.
- fifo_rd_data  in  32  FIFO read data; valid the cycle after fifo_rd_en.
- tx_data  out  8  byte to UART; held stable from tx_start until tx_busy falls.
- tx_start  out  1  one-cycle strobe to UART.
- tx_busy  in  1  UART busy; rises the cycle after tx_start and stays high until the frame completes.
- busy  out  1  high whenever state != IDLE.
- words_sent  out  CNT_W  words fully transmitted in the current or last run; saturates at all-ones.
- done  out  1  one-cycle pulse when a run returns to IDLE.

Behaviour:
- Reset: state IDLE. fifo_rd_en=0, tx_start=0, tx_data=0, busy=0, words_sent=0, done=0, byte_idx=0, word register=0.
- Reset is honoured in any state. The partially sent word is discarded, and no further strobes occur from the first post-reset cycle.
- States: IDLE, SCAN, POP, CAP, SEND, WAIT_ACK, WAIT_FREE.
- IDLE:
  - single_shot=1 and fifo_empty=0: clear words_sent, mode=SINGLE, go to POP.
  - Otherwise, enable=1: clear words_sent, latch word_limit, mode=STREAM, go to SCAN.
  - single_shot while fifo_empty=1: ignored; no done pulse.
  - single_shot takes priority over enable in the same cycle.
- SCAN (stream only):
  - enable=0: go to IDLE, pulse done.
  - Otherwise, fifo_empty=0: go to POP.
  - Otherwise, stay in SCAN with busy=1.
- POP: assert fifo_rd_en for exactly one cycle, then go to CAP. fifo_rd_en is never asserted while fifo_empty=1.
- CAP: capture fifo_rd_data into the word register, set byte_idx=0, go to SEND.
- SEND:
  - When tx_busy=0: drive tx_data with the selected byte, assert tx_start for one cycle, go to WAIT_ACK.
  - tx_start is never asserted while tx_busy=1.
- Byte select:
  - MSB_FIRST=1: byte_idx 0..3 selects [31:24], [23:16], [15:8], [7:0].
  - MSB_FIRST=0: the reverse order.
- WAIT_ACK: wait for tx_busy=1, then go to WAIT_FREE.
- WAIT_FREE: wait for tx_busy=0, then:
  - byte_idx<3: increment byte_idx, go to SEND.
  - byte_idx=3: increment words_sent (saturating), then:
    - SINGLE mode: go to IDLE, pulse done.
    - STREAM mode with limit≠0 and words_sent+1 == limit: go to IDLE, pulse done.
    - STREAM mode, enable=0: go to IDLE, pulse done.
    - Otherwise: go to SCAN.
- enable falling mid-word does not abort; the current word completes all 4 bytes.
- Latency:
  - First tx_start occurs 3 cycles after a start condition is accepted in IDLE (POP, CAP, SEND).
  - Word-to-word overhead is 3 cycles (SCAN, POP, CAP) when the FIFO is non-empty.
- word_limit changes during a run are ignored.
- single_shot pulses outside IDLE are ignored.

Test Plan:
- Single word: FIFO holds 0xA1B2C3D4, UART model busy 10 cycles, pulse single_shot -> bytes A1, B2, C3, D4 in order; one fifo_rd_en pulse; words_sent=1; one done pulse; busy=0 after.
- Limit: 5 words queued, word_limit=3, enable=1 held -> exactly 3 rd_en pulses and 12 tx_start pulses; done once; words_sent=3; 2 words remain in FIFO.
- Starvation: unlimited stream, FIFO empties after 2 words, refilled 50 cycles later -> busy stays 1 with no rd_en while empty; resumes on refill; dropping enable in SCAN gives done with words_sent=3.
- Mid-word stop: enable dropped after the 2nd byte of word 0x11223344 -> 33 and 44 still sent; then IDLE and done; no further pop.
- Reset mid-send: rst asserted in WAIT_FREE of byte 2 -> next cycle tx_start=0, fifo_rd_en=0, busy=0, words_sent=0; no further bytes.
- MSB_FIRST=0 with 0xA1B2C3D4 -> D4, C3, B2, A1. single_shot with fifo_empty=1 -> no rd_en, no tx_start, no done.
